// File: rtl/card_pkg.sv
// Shared definitions for the card linked-list blocks: word layout, null address,
// default traversal limit and FSM state encoding.
package card_pkg;

   localparam int CARD_VALID_BIT = 31;
   localparam int CARD_SUIT_HI   = 21;
   localparam int CARD_SUIT_LO   = 20;
   localparam int CARD_VALUE_HI  = 19;
   localparam int CARD_VALUE_LO  = 16;
   localparam int CARD_NEXT_HI   = 9;
   localparam int CARD_NEXT_LO   = 0;

   localparam logic [9:0] NULL_ADDR         = 10'd0;
   localparam int         DEFAULT_MAX_CARDS = 52;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      WAIT    = 3'd2,
      CHECK   = 3'd3,
      PRESENT = 3'd4,
      FINISH  = 3'd5
   } card_state_e;

   typedef struct packed {
      logic       valid;
      logic [1:0] suit;
      logic [3:0] value;
      logic [9:0] next;
   } card_word_t;

   // Unpacks a RAM word; bits outside the defined fields carry no meaning.
   function automatic card_word_t decode_card(input logic [31:0] word);
      card_word_t c;
      c.valid = word[CARD_VALID_BIT];
      c.suit  = word[CARD_SUIT_HI:CARD_SUIT_LO];
      c.value = word[CARD_VALUE_HI:CARD_VALUE_LO];
      c.next  = word[CARD_NEXT_HI:CARD_NEXT_LO];
      return c;
   endfunction

endpackage

// File: rtl/card_list_reader_if.sv
// Card presentation handshake between the list reader (master) and its consumer (slave).
interface card_list_reader_if;

   logic       card_valid;
   logic       card_ready;
   logic [3:0] card_value;
   logic [1:0] card_suit;
   logic [9:0] card_addr;

   modport master (
      output card_valid,
      output card_value,
      output card_suit,
      output card_addr,
      input  card_ready
   );

   modport slave (
      input  card_valid,
      input  card_value,
      input  card_suit,
      input  card_addr,
      output card_ready
   );

endinterface

// File: rtl/card_list_reader.sv
// Walks a linked list of card words held in a parent-owned 1024x32 RAM and
// presents each card over a valid/ready handshake, with a loop guard.
module card_list_reader
   import card_pkg::*;
#(
   parameter int MAX_CARDS = DEFAULT_MAX_CARDS
)
(
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     start,
   input  logic [9:0]               head_addr,
   output logic [9:0]               ram_address,
   input  logic [31:0]              ram_q,
   card_list_reader_if.master       card_bus,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [5:0]               count
);

   localparam logic [5:0] MAX_COUNT = 6'(MAX_CARDS);

   card_state_e state_r, state_s;

   logic [9:0] ram_address_r, ram_address_s;
   logic       card_valid_r,  card_valid_s;
   logic [3:0] card_value_r,  card_value_s;
   logic [1:0] card_suit_r,   card_suit_s;
   logic [9:0] card_addr_r,   card_addr_s;
   logic [9:0] next_r,        next_s;
   logic       busy_r,        busy_s;
   logic       done_r,        done_s;
   logic       error_r,       error_s;
   logic [5:0] count_r,       count_s;

   card_word_t word_s;
   logic       accept_s;
   logic       limit_s;

   assign word_s   = decode_card(ram_q);
   assign accept_s = card_valid_r & card_bus.card_ready;
   assign limit_s  = (count_r == MAX_COUNT);

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (head_addr == NULL_ADDR) begin
                  state_s = FINISH;
               end else begin
                  state_s = FETCH;
               end
            end else begin
               state_s = IDLE;
            end
         end
         FETCH:   state_s = WAIT;
         WAIT:    state_s = CHECK;
         CHECK: begin
            if (!word_s.valid || limit_s) begin
               state_s = FINISH;
            end else begin
               state_s = PRESENT;
            end
         end
         PRESENT: begin
            if (accept_s) begin
               if (next_r == NULL_ADDR) begin
                  state_s = FINISH;
               end else begin
                  state_s = FETCH;
               end
            end else begin
               state_s = PRESENT;
            end
         end
         FINISH:  state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath.
   always_comb begin
      ram_address_s = ram_address_r;
      card_valid_s  = card_valid_r;
      card_value_s  = card_value_r;
      card_suit_s   = card_suit_r;
      card_addr_s   = card_addr_r;
      next_s        = next_r;
      busy_s        = busy_r;
      done_s        = 1'b0;
      error_s       = error_r;
      count_s       = count_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               ram_address_s = head_addr;
               count_s       = 6'd0;
               error_s       = 1'b0;
               busy_s        = 1'b1;
            end else begin
               busy_s        = 1'b0;
            end
         end
         CHECK: begin
            // The loop guard wins over presenting: a list longer than the limit never shows the extra card.
            if (!word_s.valid || limit_s) begin
               error_s       = 1'b1;
            end else begin
               card_valid_s  = 1'b1;
               card_value_s  = word_s.value;
               card_suit_s   = word_s.suit;
               card_addr_s   = ram_address_r;
               next_s        = word_s.next;
            end
         end
         PRESENT: begin
            if (accept_s) begin
               card_valid_s  = 1'b0;
               count_s       = count_r + 6'd1;
               if (next_r != NULL_ADDR) begin
                  ram_address_s = next_r;
               end else begin
                  ram_address_s = ram_address_r;
               end
            end else begin
               card_valid_s  = 1'b1;
            end
         end
         FINISH: begin
            done_s = 1'b1;
            busy_s = 1'b0;
         end
         default: begin
            card_valid_s = card_valid_r;
         end
      endcase
   end

   // Output and datapath registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ram_address_r <= 10'd0;
         card_valid_r  <= 1'b0;
         card_value_r  <= 4'd0;
         card_suit_r   <= 2'd0;
         card_addr_r   <= 10'd0;
         next_r        <= 10'd0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         error_r       <= 1'b0;
         count_r       <= 6'd0;
      end else begin
         ram_address_r <= ram_address_s;
         card_valid_r  <= card_valid_s;
         card_value_r  <= card_value_s;
         card_suit_r   <= card_suit_s;
         card_addr_r   <= card_addr_s;
         next_r        <= next_s;
         busy_r        <= busy_s;
         done_r        <= done_s;
         error_r       <= error_s;
         count_r       <= count_s;
      end
   end

   assign ram_address         = ram_address_r;
   assign card_bus.card_valid = card_valid_r;
   assign card_bus.card_value = card_value_r;
   assign card_bus.card_suit  = card_suit_r;
   assign card_bus.card_addr  = card_addr_r;
   assign busy                = busy_r;
   assign done                = done_r;
   assign error               = error_r;
   assign count               = count_r;

endmodule

// File: tb/tb_card_list_reader.sv
// Bench for card_list_reader: RAM model with two-cycle read latency, a list-walking
// reference model, directed scenario table, reset-in-flight case and random lists.
module tb_card_list_reader;
   import card_pkg::*;

   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic [9:0]  head_addr;
   logic [9:0]  ram_address;
   logic [31:0] ram_q;
   logic        busy, done, error;
   logic [5:0]  count;

   card_list_reader_if card_bus();

   card_list_reader #(.MAX_CARDS(52)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .start       (start),
      .head_addr   (head_addr),
      .ram_address (ram_address),
      .ram_q       (ram_q),
      .card_bus    (card_bus),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .count       (count)
   );

   always #5 clock = ~clock;

   logic [31:0] mem [0:1023];
   logic [31:0] q_pipe;

   always @(posedge clock) begin
      q_pipe <= mem[ram_address];
      ram_q  <= q_pipe;
   end

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] value;
      logic [1:0] suit;
      logic [9:0] addr;
   } card_t;

   card_t exp_q[$];
   int    exp_count;
   bit    exp_err;

   typedef struct {
      int         scen;
      logic [9:0] head;
      int         mode;
      int         exp_count;
      bit         exp_err;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic logic [31:0] mk(input bit v, input int suit, input int value, input int nxt);
      logic [31:0] w;
      w = $urandom;
      w[31]    = v;
      w[21:20] = 2'(suit);
      w[19:16] = 4'(value);
      w[9:0]   = 10'(nxt);
      return w;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
   endtask

   // Reference: follow next pointers, stop on null, invalid word or 52 cards already shown.
   task automatic build_model(input logic [9:0] head);
      logic [9:0]  a;
      logic [31:0] w;
      card_t       c;
      a = head;
      exp_q.delete();
      exp_err = 1'b0;
      while (a != 10'd0) begin
         w = mem[a];
         if (!w[31]) begin exp_err = 1'b1; break; end
         if (exp_q.size() == 52) begin exp_err = 1'b1; break; end
         c.value = w[19:16];
         c.suit  = w[21:20];
         c.addr  = a;
         exp_q.push_back(c);
         a = w[9:0];
      end
      exp_count = exp_q.size();
   endtask

   task automatic load_scen(input int id);
      clear_mem();
      case (id)
         0, 4: begin
            mem[5] = mk(1'b1, 0, 2, 9);
            mem[9] = mk(1'b1, 1, 11, 3);
            mem[3] = mk(1'b1, 3, 13, 0);
         end
         2: mem[7] = mk(1'b0, 2, 5, 0);
         3: mem[4] = mk(1'b1, 2, 6, 4);
         default: ;
      endcase
   endtask

   // mode 0: ready always high; 1: random ready and stray starts; 2: ready low 10 cycles on 2nd card
   task automatic run_trav(input logic [9:0] head, input int mode, input string tag);
      int  idx = 0, cyc = 0, stall = 0, last_acc = 0;
      bit  prev_valid = 1'b0, seen_done = 1'b0, rdy;
      build_model(head);
      @(negedge clock);
      head_addr = head;
      start     = 1'b1;
      card_bus.card_ready = 1'b1;
      while (1) begin
         @(negedge clock);
         cyc++;
         start = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (mode == 1) head_addr = 10'($urandom);
         check({tag, "_busy"}, busy, !done);
         if (card_bus.card_valid) begin
            if (idx >= exp_q.size()) begin
               check({tag, "_extra_card"}, card_bus.card_valid, 1'b0);
            end else begin
               check({tag, "_value"}, card_bus.card_value, exp_q[idx].value);
               check({tag, "_suit"},  card_bus.card_suit,  exp_q[idx].suit);
               check({tag, "_addr"},  card_bus.card_addr,  exp_q[idx].addr);
               if (mode == 0 && !prev_valid)
                  check({tag, "_latency"}, cyc - last_acc, 4);
            end
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = 1'($urandom_range(0, 1));
               default: rdy = !(idx == 1 && stall < 10);
            endcase
            if (!rdy) stall++;
            card_bus.card_ready = rdy;
            if (rdy) begin idx++; last_acc = cyc; end
         end else begin
            card_bus.card_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         prev_valid = card_bus.card_valid;
         if (done) begin
            seen_done = 1'b1;
            if (!exp_err) check({tag, "_done_time"}, cyc, last_acc + 2);
            break;
         end
         if (cyc > 3000) break;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, seen_done, 1'b1);
      check({tag, "_accepted"}, idx, exp_count);
      check({tag, "_count"}, count, exp_count);
      check({tag, "_error"}, error, exp_err);
      if (mode == 2) check({tag, "_stall_len"}, stall, 10);
      @(negedge clock);
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_idle_busy"}, busy, 1'b0);
      check({tag, "_idle_valid"}, card_bus.card_valid, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ram_address"}, ram_address, 0);
      check({tag, "_valid"}, card_bus.card_valid, 0);
      check({tag, "_value"}, card_bus.card_value, 0);
      check({tag, "_suit"}, card_bus.card_suit, 0);
      check({tag, "_addr"}, card_bus.card_addr, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_count"}, count, 0);
   endtask

   initial begin
      int          len, n;
      logic [9:0]  addrs[$];
      logic [9:0]  a;
      bit          used;
      bit          found;

      resetn = 1'b0;
      start  = 1'b0;
      head_addr = 10'd0;
      card_bus.card_ready = 1'b0;
      clear_mem();
      repeat (2) @(negedge clock);
      check_all_zero("reset");
      resetn = 1'b1;
      repeat (3) @(negedge clock);
      check("post_reset_valid", card_bus.card_valid, 1'b0);

      vecs[0] = '{0, 10'd5, 0, 3,  1'b0};
      vecs[1] = '{1, 10'd0, 0, 0,  1'b0};
      vecs[2] = '{2, 10'd7, 0, 0,  1'b1};
      vecs[3] = '{3, 10'd4, 0, 52, 1'b1};
      vecs[4] = '{4, 10'd5, 2, 3,  1'b0};
      for (int v = 0; v < 5; v++) begin
         load_scen(vecs[v].scen);
         run_trav(vecs[v].head, vecs[v].mode, $sformatf("vec%0d", v));
         check($sformatf("vec%0d_tbl_count", v), count, vecs[v].exp_count);
         check($sformatf("vec%0d_tbl_error", v), error, vecs[v].exp_err);
      end

      // Reset while the second card is being presented.
      load_scen(0);
      @(negedge clock);
      head_addr = 10'd5;
      start = 1'b1;
      card_bus.card_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clock);
         start = 1'b0;
         if (card_bus.card_valid && card_bus.card_addr == 10'd9) begin
            card_bus.card_ready = 1'b0;
            found = 1'b1;
            break;
         end
      end
      check("rst_second_card_seen", found, 1'b1);
      #2 resetn = 1'b0;
      #1 check_all_zero("rst_mid");
      @(negedge clock);
      resetn = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         check("rst_no_spurious_valid", card_bus.card_valid, 1'b0);
      end
      run_trav(10'd5, 0, "rst_again");

      // Random lists with random ready and stray start pulses while busy.
      for (int it = 0; it < 20; it++) begin
         clear_mem();
         addrs.delete();
         len = $urandom_range(1, 8);
         while (addrs.size() < len) begin
            a = 10'($urandom_range(1, 1023));
            used = 1'b0;
            foreach (addrs[k]) if (addrs[k] == a) used = 1'b1;
            if (!used) addrs.push_back(a);
         end
         n = addrs.size();
         for (int k = 0; k < n; k++)
            mem[addrs[k]] = mk(($urandom_range(0, 5) != 0), $urandom_range(0, 3),
                               $urandom_range(0, 15), (k == n - 1) ? 0 : int'(addrs[k + 1]));
         run_trav(addrs[0], 1, $sformatf("rand%0d", it));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
